// File: rtl/branch_unit_bht_if.sv
// Execute/fetch-side bundle of the branch unit: prediction lookup, branch
// resolution request and registered resolution result.
interface branch_unit_bht_if #(
   parameter int unsigned XLEN = 32
);
   logic [XLEN-1:0] f_pc;
   logic            f_pred_taken;
   logic            ex_valid;
   logic            ex_flush;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_srca;
   logic [XLEN-1:0] ex_srcb;
   logic [3:0]      ex_alucontrol;
   logic [XLEN-1:0] ex_target;
   logic            ex_pred_taken;
   logic            r_valid;
   logic            r_taken;
   logic            r_mispredict;
   logic [XLEN-1:0] r_redirect_pc;

   modport master (
      output f_pc, ex_valid, ex_flush, ex_pc, ex_srca, ex_srcb,
             ex_alucontrol, ex_target, ex_pred_taken,
      input  f_pred_taken, r_valid, r_taken, r_mispredict, r_redirect_pc
   );

   modport slave (
      input  f_pc, ex_valid, ex_flush, ex_pc, ex_srca, ex_srcb,
             ex_alucontrol, ex_target, ex_pred_taken,
      output f_pred_taken, r_valid, r_taken, r_mispredict, r_redirect_pc
   );
endinterface

// File: rtl/branch_unit_bht.sv
// Branch resolution unit: evaluates branch/jump conditions, registers the
// outcome and redirect PC, trains a bimodal BHT and counts branches/mispredicts.
module branch_unit_bht #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned BHT_IDX = 6,
   parameter int unsigned CNT_W   = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   branch_unit_bht_if.slave  bus,
   output logic [CNT_W-1:0]  br_count,
   output logic [CNT_W-1:0]  mp_count
);
   localparam int unsigned BHT_N = 1 << BHT_IDX;

   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_SLTU = 4'b0110;
   localparam logic [3:0] OP_EQ   = 4'b1010;
   localparam logic [3:0] OP_NE   = 4'b1011;
   localparam logic [3:0] OP_SGE  = 4'b1100;
   localparam logic [3:0] OP_SGEU = 4'b1101;
   localparam logic [3:0] OP_JMP  = 4'b1111;

   logic                        r_valid_q, r_valid_d;
   logic                        r_taken_q, r_taken_d;
   logic                        r_mispredict_q, r_mispredict_d;
   logic [XLEN-1:0]             r_redirect_pc_q, r_redirect_pc_d;
   logic [BHT_N-1:0][1:0]       bht_q, bht_d;
   logic [CNT_W-1:0]            br_count_q, br_count_d;
   logic [CNT_W-1:0]            mp_count_q, mp_count_d;

   logic                        is_cond;
   logic                        is_jump;
   logic                        cond;
   logic                        accept;
   logic [BHT_IDX-1:0]          ex_idx;
   logic [BHT_IDX-1:0]          f_idx;
   logic                        unused_f_pc_bits;

   assign ex_idx = bus.ex_pc[BHT_IDX+1:2];
   assign f_idx  = bus.f_pc[BHT_IDX+1:2];
   assign unused_f_pc_bits = ^{bus.f_pc[XLEN-1:BHT_IDX+2], bus.f_pc[1:0]};

   // Condition decode; unknown codes are not branches.
   always_comb begin
      is_cond = 1'b0;
      is_jump = 1'b0;
      cond    = 1'b0;
      unique case (bus.ex_alucontrol)
         OP_SLT:  begin is_cond = 1'b1; cond = $signed(bus.ex_srca) <  $signed(bus.ex_srcb); end
         OP_SLTU: begin is_cond = 1'b1; cond = bus.ex_srca <  bus.ex_srcb; end
         OP_EQ:   begin is_cond = 1'b1; cond = bus.ex_srca == bus.ex_srcb; end
         OP_NE:   begin is_cond = 1'b1; cond = bus.ex_srca != bus.ex_srcb; end
         OP_SGE:  begin is_cond = 1'b1; cond = $signed(bus.ex_srca) >= $signed(bus.ex_srcb); end
         OP_SGEU: begin is_cond = 1'b1; cond = bus.ex_srca >= bus.ex_srcb; end
         OP_JMP:  begin is_jump = 1'b1; cond = 1'b1; end
         default: ;
      endcase
      accept = bus.ex_valid & ~bus.ex_flush & (is_cond | is_jump);
   end

   // Next-state: result registers, BHT training and performance counters.
   always_comb begin
      r_valid_d       = accept;
      r_taken_d       = accept & cond;
      r_mispredict_d  = accept & (cond ^ bus.ex_pred_taken);
      r_redirect_pc_d = r_redirect_pc_q;
      bht_d           = bht_q;
      br_count_d      = br_count_q;
      mp_count_d      = mp_count_q;
      if (accept) begin
         r_redirect_pc_d = cond ? bus.ex_target : bus.ex_pc + XLEN'(4);
      end
      if (accept && is_cond) begin
         br_count_d = br_count_q + CNT_W'(1);
         if (cond && (bht_q[ex_idx] != 2'b11)) begin
            bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
         end else if (!cond && (bht_q[ex_idx] != 2'b00)) begin
            bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
         end
      end
      if (r_mispredict_d) begin
         mp_count_d = mp_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid_q       <= 1'b0;
         r_taken_q       <= 1'b0;
         r_mispredict_q  <= 1'b0;
         r_redirect_pc_q <= '0;
         for (int i = 0; i < BHT_N; i++) begin
            bht_q[i] <= 2'b01;
         end
         br_count_q      <= '0;
         mp_count_q      <= '0;
      end else begin
         r_valid_q       <= r_valid_d;
         r_taken_q       <= r_taken_d;
         r_mispredict_q  <= r_mispredict_d;
         r_redirect_pc_q <= r_redirect_pc_d;
         bht_q           <= bht_d;
         br_count_q      <= br_count_d;
         mp_count_q      <= mp_count_d;
      end
   end

   // Prediction reads the pre-update table, so a same-cycle update is seen next cycle.
   assign bus.f_pred_taken  = bht_q[f_idx][1];
   assign bus.r_valid       = r_valid_q;
   assign bus.r_taken       = r_taken_q;
   assign bus.r_mispredict  = r_mispredict_q;
   assign bus.r_redirect_pc = r_redirect_pc_q;
   assign br_count          = br_count_q;
   assign mp_count          = mp_count_q;
endmodule

// File: tb/tb_branch_unit_bht.sv
// Self-checking bench for branch_unit_bht: directed scenarios plus randomized
// traffic against a behavioural model of the branch rules and BHT.
module tb_branch_unit_bht;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] br_count, mp_count;
   logic [3:0]  br_count4, mp_count4;

   branch_unit_bht_if #(.XLEN(32)) bus ();
   branch_unit_bht_if #(.XLEN(32)) bus4 ();

   branch_unit_bht #(.XLEN(32), .BHT_IDX(6), .CNT_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .br_count(br_count), .mp_count(mp_count));
   branch_unit_bht #(.XLEN(32), .BHT_IDX(6), .CNT_W(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .bus(bus4), .br_count(br_count4), .mp_count(mp_count4));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // Behavioural reference state
   int          m_bht [64];
   logic        m_rv, m_rt, m_rm;
   logic [31:0] m_rpc, m_br, m_mp;

   function automatic void ref_decode(input logic [3:0] code, input logic [31:0] a, b,
                                      output logic isc, output logic isj, output logic c);
      isc = 1'b1; isj = 1'b0; c = 1'b0;
      case (code)
         4'b0101: c = (int'(a) <  int'(b));
         4'b0110: c = (a <  b);
         4'b1010: c = (a == b);
         4'b1011: c = (a != b);
         4'b1100: c = (int'(a) >= int'(b));
         4'b1101: c = (a >= b);
         4'b1111: begin isc = 1'b0; isj = 1'b1; c = 1'b1; end
         default: isc = 1'b0;
      endcase
   endfunction

   function automatic logic ref_pred(input logic [31:0] pc);
      return m_bht[(pc >> 2) % 64] >= 2;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
      m_rv = 0; m_rt = 0; m_rm = 0; m_rpc = 0; m_br = 0; m_mp = 0;
   endtask

   task automatic model_update();
      logic isc, isj, c;
      int   idx;
      ref_decode(bus.ex_alucontrol, bus.ex_srca, bus.ex_srcb, isc, isj, c);
      idx = (bus.ex_pc >> 2) % 64;
      if (bus.ex_valid && !bus.ex_flush && (isc || isj)) begin
         m_rv = 1; m_rt = c; m_rm = c ^ bus.ex_pred_taken;
         m_rpc = c ? bus.ex_target : bus.ex_pc + 32'd4;
         if (isc) begin
            m_br = m_br + 32'd1;
            m_bht[idx] = c ? ((m_bht[idx] == 3) ? 3 : m_bht[idx] + 1)
                           : ((m_bht[idx] == 0) ? 0 : m_bht[idx] - 1);
         end
         if (m_rm) m_mp = m_mp + 32'd1;
      end else begin
         m_rv = 0; m_rt = 0; m_rm = 0;
      end
   endtask

   task automatic set_ex(input logic v, input logic f, input logic [31:0] pc, a, b,
                         input logic [3:0] code, input logic [31:0] tgt, input logic pred);
      @(negedge clk);
      bus.ex_valid = v; bus.ex_flush = f; bus.ex_pc = pc; bus.ex_srca = a; bus.ex_srcb = b;
      bus.ex_alucontrol = code; bus.ex_target = tgt; bus.ex_pred_taken = pred;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         set_ex(1'b1, 1'b0, $urandom, $urandom, $urandom, 4'b1111, $urandom, 1'b0);
         tick();
      end
      #1 reset_n = 1'b0;
      bus.f_pc = 32'h0;
      #1;
      n_cmp++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_r_valid got %0b want 0", bus.r_valid); end
      n_cmp++; if (bus.r_taken !== 1'b0) begin n_fail++; $display("FAIL reset_r_taken got %0b want 0", bus.r_taken); end
      n_cmp++; if (bus.r_mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_r_mispredict got %0b want 0", bus.r_mispredict); end
      n_cmp++; if (bus.r_redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect got %h want 0", bus.r_redirect_pc); end
      n_cmp++; if (br_count !== 32'h0 || mp_count !== 32'h0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", br_count, mp_count); end
      n_cmp++; if (bus.f_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_0 got %0b want 0", bus.f_pred_taken); end
      bus.f_pc = 32'hFC;
      #1;
      n_cmp++; if (bus.f_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_fc got %0b want 0", bus.f_pred_taken); end
      model_reset();
      @(negedge clk);
      bus.ex_valid = 1'b0;
      reset_n = 1'b1;
      tick();
      n_cmp++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got %0b want 0", bus.r_valid); end
   endtask

   task automatic test_signed_unsigned();
      logic [3:0] codes [3];
      logic       want [3];
      codes = '{4'b0101, 4'b0110, 4'b1101};
      want  = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         set_ex(1'b1, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'h1, codes[i], 32'h300, 1'b0);
         tick();
         n_cmp++; if (bus.r_valid !== 1'b1 || bus.r_taken !== want[i]) begin n_fail++; $display("FAIL sign_code_%b valid/taken got %0b/%0b want 1/%0b", codes[i], bus.r_valid, bus.r_taken, want[i]); end
         n_cmp++; if (bus.r_mispredict !== want[i]) begin n_fail++; $display("FAIL sign_mispredict_%b got %0b want %0b", codes[i], bus.r_mispredict, want[i]); end
      end
   endtask

   task automatic test_redirect();
      set_ex(1'b1, 1'b0, 32'h100, 32'h5, 32'h5, 4'b1010, 32'h80, 1'b1);
      tick();
      n_cmp++; if (bus.r_redirect_pc !== 32'h80) begin n_fail++; $display("FAIL redirect_taken got %h want 00000080", bus.r_redirect_pc); end
      set_ex(1'b1, 1'b0, 32'h100, 32'h5, 32'h6, 4'b1010, 32'h80, 1'b0);
      tick();
      n_cmp++; if (bus.r_redirect_pc !== 32'h104) begin n_fail++; $display("FAIL redirect_fall got %h want 00000104", bus.r_redirect_pc); end
      set_ex(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1, 32'h2, 4'b1010, 32'h80, 1'b0);
      tick();
      n_cmp++; if (bus.r_redirect_pc !== 32'h0) begin n_fail++; $display("FAIL redirect_wrap got %h want 00000000", bus.r_redirect_pc); end
      set_ex(1'b0, 1'b0, 32'h100, 32'h5, 32'h5, 4'b1010, 32'h80, 1'b0);
      tick();
      n_cmp++; if (bus.r_redirect_pc !== 32'h0 || bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_hold got %h/%0b want 00000000/0", bus.r_redirect_pc, bus.r_valid); end
   endtask

   task automatic test_bht_training();
      logic pre [5];
      logic post [5];
      pre  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      post = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      bus.f_pc = 32'h40;
      for (int i = 0; i < 5; i++) begin
         // first three taken (ne, operands differ), last two not taken
         set_ex(1'b1, 1'b0, 32'h40, 32'h1, (i < 3) ? 32'h2 : 32'h1, 4'b1011, 32'h90, 1'b0);
         #1;
         n_cmp++; if (bus.f_pred_taken !== pre[i]) begin n_fail++; $display("FAIL bht_pre_%0d got %0b want %0b", i, bus.f_pred_taken, pre[i]); end
         tick();
         n_cmp++; if (bus.f_pred_taken !== post[i]) begin n_fail++; $display("FAIL bht_post_%0d got %0b want %0b", i, bus.f_pred_taken, post[i]); end
      end
   endtask

   task automatic test_flush_illegal();
      logic [31:0] br0, mp0;
      logic        p0;
      bus.f_pc = 32'h44;
      br0 = m_br; mp0 = m_mp; p0 = ref_pred(32'h44);
      for (int i = 0; i < 3; i++) begin
         if (i == 0) set_ex(1'b1, 1'b1, 32'h44, 32'h1, 32'h2, 4'b1011, 32'h90, 1'b0);
         else if (i == 1) set_ex(1'b0, 1'b0, 32'h44, 32'h1, 32'h2, 4'b1011, 32'h90, 1'b0);
         else set_ex(1'b1, 1'b0, 32'h44, 32'h1, 32'h2, 4'b0000, 32'h90, 1'b0);
         tick();
         n_cmp++; if (bus.r_valid !== 1'b0 || bus.r_taken !== 1'b0) begin n_fail++; $display("FAIL kill_%0d valid/taken got %0b/%0b want 0/0", i, bus.r_valid, bus.r_taken); end
         n_cmp++; if (br_count !== br0 || mp_count !== mp0 || bus.f_pred_taken !== p0) begin n_fail++; $display("FAIL kill_state_%0d got %0d/%0d/%0b want %0d/%0d/%0b", i, br_count, mp_count, bus.f_pred_taken, br0, mp0, p0); end
      end
      set_ex(1'b1, 1'b0, 32'h44, 32'h1, 32'h2, 4'b1111, 32'hA0, 1'b0);
      tick();
      n_cmp++; if (bus.r_taken !== 1'b1 || bus.r_redirect_pc !== 32'hA0) begin n_fail++; $display("FAIL jump_taken got %0b/%h want 1/000000a0", bus.r_taken, bus.r_redirect_pc); end
      n_cmp++; if (mp_count !== mp0 + 32'd1 || br_count !== br0) begin n_fail++; $display("FAIL jump_counts got %0d/%0d want %0d/%0d", br_count, mp_count, br0, mp0 + 32'd1); end
      n_cmp++; if (bus.f_pred_taken !== p0) begin n_fail++; $display("FAIL jump_bht got %0b want %0b", bus.f_pred_taken, p0); end
   endtask

   task automatic test_random();
      logic [31:0] pc, a, b, fpc;
      for (int i = 0; i < 300; i++) begin
         pc = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7) << 2);
         a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4)) : $urandom);
         set_ex($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, pc, a, b,
                4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
         fpc = ($urandom_range(0, 1) == 0) ? pc : 32'($urandom_range(0, 7) << 2);
         bus.f_pc = fpc;
         #1;
         n_cmp++; if (bus.f_pred_taken !== ref_pred(fpc)) begin n_fail++; $display("FAIL rand_pred_%0d pc %h got %0b want %0b", i, fpc, bus.f_pred_taken, ref_pred(fpc)); end
         tick();
         n_cmp++;
         if (bus.r_valid !== m_rv || bus.r_taken !== m_rt || bus.r_mispredict !== m_rm || bus.r_redirect_pc !== m_rpc) begin
            n_fail++;
            $display("FAIL rand_result_%0d got v%0b t%0b m%0b pc %h want v%0b t%0b m%0b pc %h", i,
                     bus.r_valid, bus.r_taken, bus.r_mispredict, bus.r_redirect_pc, m_rv, m_rt, m_rm, m_rpc);
         end
         n_cmp++; if (br_count !== m_br || mp_count !== m_mp) begin n_fail++; $display("FAIL rand_counts_%0d got %0d/%0d want %0d/%0d", i, br_count, mp_count, m_br, m_mp); end
      end
   endtask

   task automatic test_counter_wrap();
      bus.ex_valid = 1'b0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         bus4.ex_valid = 1'b1; bus4.ex_flush = 1'b0; bus4.ex_pc = 32'h80; bus4.ex_srca = 32'h0;
         bus4.ex_srcb = 32'h1; bus4.ex_alucontrol = 4'b0101; bus4.ex_target = 32'hC0; bus4.ex_pred_taken = 1'b0;
      end
      @(negedge clk);
      bus4.ex_valid = 1'b0;
      n_cmp++; if (br_count4 !== 4'(17 % 16)) begin n_fail++; $display("FAIL wrap_br got %0d want %0d", br_count4, 17 % 16); end
      n_cmp++; if (mp_count4 !== 4'(17 % 16)) begin n_fail++; $display("FAIL wrap_mp got %0d want %0d", mp_count4, 17 % 16); end
   endtask

   initial begin
      bus.f_pc = '0; bus.ex_valid = 1'b0; bus.ex_flush = 1'b0; bus.ex_pc = '0; bus.ex_srca = '0;
      bus.ex_srcb = '0; bus.ex_alucontrol = '0; bus.ex_target = '0; bus.ex_pred_taken = 1'b0;
      bus4.f_pc = '0; bus4.ex_valid = 1'b0; bus4.ex_flush = 1'b0; bus4.ex_pc = '0; bus4.ex_srca = '0;
      bus4.ex_srcb = '0; bus4.ex_alucontrol = '0; bus4.ex_target = '0; bus4.ex_pred_taken = 1'b0;
      model_reset();
      #12 reset_n = 1'b1;
      test_reset();
      test_signed_unsigned();
      test_redirect();
      test_bht_training();
      test_flush_illegal();
      test_random();
      test_counter_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
